// File: rtl/gpll_reconfig_pkg.sv
// Shared types and constants for the GPLL dynamic-reconfiguration sequencer:
// FSM states, APB widths, error codes and the stored clock-profile tables.
package gpll_reconfig_pkg;

    localparam int unsigned APB_AW = 5;
    localparam int unsigned APB_DW = 16;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_BAD_PROF = 2'd1;
    localparam logic [1:0] ERR_READBACK = 2'd2;
    localparam logic [1:0] ERR_LOCK_TO  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_ASSERT,
        ST_WR_SETUP,
        ST_WR_ACCESS,
        ST_RD_SETUP,
        ST_RD_ACCESS,
        ST_WAIT_LOCK
    } state_e;

    typedef struct packed {
        logic [APB_AW-1:0] addr;
        logic [APB_DW-1:0] data;
    } prof_entry_t;

    // Profile 0: 74.25/371.25 MHz HDMI, 1: 148.5/742.5 MHz, 2: 27/135 MHz SD video
    localparam int unsigned TBL_PROFILES = 3;
    localparam int unsigned TBL_WRITES   = 8;
    localparam int unsigned TBL_PW       = 2;
    localparam int unsigned TBL_IW       = 3;

    localparam logic [APB_AW-1:0] TBL_ADDR [TBL_WRITES] = '{
        5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h08, 5'h09, 5'h0c
    };

    localparam logic [APB_DW-1:0] TBL_DATA [TBL_PROFILES][TBL_WRITES] = '{
        '{16'h0005, 16'h0028, 16'h0001, 16'h0005, 16'h0001, 16'h3c10, 16'h0a21, 16'h8001},
        '{16'h0005, 16'h0050, 16'h0001, 16'h0005, 16'h0002, 16'h3c12, 16'h0a31, 16'h8001},
        '{16'h0008, 16'h0064, 16'h0003, 16'h000a, 16'h0004, 16'h2c08, 16'h0921, 16'h8000}
    };

endpackage

// File: rtl/gpll_profile_rom.sv
// Combinational profile lookup: (profile, word index) -> APB address/data entry.
module gpll_profile_rom
    import gpll_reconfig_pkg::*;
#(
    parameter int unsigned PW = 1
) (
    input  logic [PW-1:0] prof_i,
    input  logic [4:0]    idx_i,
    output prof_entry_t   entry_c
);

    logic [TBL_PW-1:0] prof_c;
    logic [TBL_IW-1:0] idx_c;

    assign prof_c = TBL_PW'(prof_i);
    assign idx_c  = TBL_IW'(idx_i);

    // Entries outside the stored tables map to a harmless zero write at addr=idx
    always_comb begin
        entry_c.addr = APB_AW'(idx_i);
        entry_c.data = '0;
        if ((32'(prof_i) < TBL_PROFILES) && (32'(idx_i) < TBL_WRITES)) begin
            entry_c.addr = TBL_ADDR[idx_c];
            entry_c.data = TBL_DATA[prof_c][idx_c];
        end
    end

endmodule

// File: rtl/gpll_reconfig_ctrl.sv
// APB master sequencer that reloads a stored profile into the GPLL reconfig port,
// verifies each word by readback, then waits for a debounced lock.
module gpll_reconfig_ctrl
    import gpll_reconfig_pkg::*;
#(
    parameter int unsigned NUM_PROFILES = 2,
    parameter int unsigned NUM_WRITES   = 8,
    parameter int unsigned RST_HOLD     = 16,
    parameter int unsigned LOCK_STABLE  = 8,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    localparam int unsigned PW = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1
) (
    input  logic              apb_clk,
    input  logic              apb_rst_n,
    input  logic              req,
    input  logic [PW-1:0]     prof_sel,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              locked,
    input  logic              pll_lock,
    output logic              pll_rst,
    output logic              apb_sel,
    output logic              apb_en,
    output logic              apb_write,
    output logic [APB_AW-1:0] apb_addr,
    output logic [APB_DW-1:0] apb_wdata,
    input  logic [APB_DW-1:0] apb_rdata,
    input  logic              apb_ready
);

    localparam int unsigned SW = $clog2(LOCK_STABLE + 1);
    localparam int unsigned CW = 16;

    state_e            state_q, state_d;
    logic [PW-1:0]     prof_q, prof_d;
    logic [4:0]        idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     stab_q, stab_d;
    logic              lock_meta_q, lock_sync_q;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d, locked_q, locked_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              pll_rst_q, pll_rst_d;
    logic              sel_q, sel_d, en_q, en_d, write_q, write_d;
    logic [APB_AW-1:0] addr_q, addr_d;
    logic [APB_DW-1:0] wdata_q, wdata_d;
    logic [4:0]        rom_idx_c;
    prof_entry_t       rom_entry_c;
    logic              lock_ok_c;

    // The ROM is only consulted when loading word 0 or the word after the current one
    assign rom_idx_c = (state_q == ST_RD_ACCESS) ? (idx_q + 5'd1) : 5'd0;

    gpll_profile_rom #(.PW(PW)) u_rom (
        .prof_i  (prof_q),
        .idx_i   (rom_idx_c),
        .entry_c (rom_entry_c)
    );

    always_comb begin
        state_d    = state_q;
        prof_d     = prof_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        locked_d   = 1'b0;
        pll_rst_d  = pll_rst_q;
        sel_d      = sel_q;
        en_d       = en_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        // Saturating count of consecutive synced-high lock samples; stale lock is discarded while reprogramming
        if (!lock_sync_q || (state_q != ST_IDLE && state_q != ST_WAIT_LOCK)) begin
            stab_d = '0;
        end else if (stab_q == SW'(LOCK_STABLE)) begin
            stab_d = stab_q;
        end else begin
            stab_d = stab_q + SW'(1);
        end
        lock_ok_c = (stab_d == SW'(LOCK_STABLE));

        case (state_q)
            ST_IDLE: begin
                locked_d = lock_ok_c;
                if (req) begin
                    if (32'(prof_sel) >= NUM_PROFILES) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_BAD_PROF;
                    end else begin
                        prof_d     = prof_sel;
                        busy_d     = 1'b1;
                        err_code_d = ERR_NONE;
                        idx_d      = '0;
                        cnt_d      = '0;
                        pll_rst_d  = 1'b1;
                        locked_d   = 1'b0;
                        state_d    = ST_RST_ASSERT;
                    end
                end
            end
            ST_RST_ASSERT: begin
                if (cnt_q == CW'(RST_HOLD - 1)) begin
                    sel_d   = 1'b1;
                    en_d    = 1'b0;
                    write_d = 1'b1;
                    addr_d  = rom_entry_c.addr;
                    wdata_d = rom_entry_c.data;
                    cnt_d   = '0;
                    state_d = ST_WR_SETUP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WR_SETUP: begin
                en_d    = 1'b1;
                state_d = ST_WR_ACCESS;
            end
            ST_WR_ACCESS: begin
                if (apb_ready) begin
                    en_d    = 1'b0;
                    write_d = 1'b0;
                    state_d = ST_RD_SETUP;
                end
            end
            ST_RD_SETUP: begin
                en_d    = 1'b1;
                state_d = ST_RD_ACCESS;
            end
            ST_RD_ACCESS: begin
                if (apb_ready) begin
                    en_d = 1'b0;
                    if (apb_rdata != wdata_q) begin
                        // PLL is left in reset so a half-written profile never runs
                        err_d      = 1'b1;
                        err_code_d = ERR_READBACK;
                        busy_d     = 1'b0;
                        sel_d      = 1'b0;
                        state_d    = ST_IDLE;
                    end else if (idx_q == 5'(NUM_WRITES - 1)) begin
                        sel_d     = 1'b0;
                        pll_rst_d = 1'b0;
                        cnt_d     = '0;
                        state_d   = ST_WAIT_LOCK;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        write_d = 1'b1;
                        addr_d  = rom_entry_c.addr;
                        wdata_d = rom_entry_c.data;
                        state_d = ST_WR_SETUP;
                    end
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_ok_c) begin
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    locked_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_LOCK_TO;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge apb_clk or negedge apb_rst_n) begin
        if (!apb_rst_n) begin
            state_q     <= ST_IDLE;
            prof_q      <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            stab_q      <= '0;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            locked_q    <= 1'b0;
            pll_rst_q   <= 1'b0;
            sel_q       <= 1'b0;
            en_q        <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            prof_q      <= prof_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            stab_q      <= stab_d;
            lock_meta_q <= pll_lock;
            lock_sync_q <= lock_meta_q;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            locked_q    <= locked_d;
            pll_rst_q   <= pll_rst_d;
            sel_q       <= sel_d;
            en_q        <= en_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign locked    = locked_q;
    assign pll_rst   = pll_rst_q;
    assign apb_sel   = sel_q;
    assign apb_en    = en_q;
    assign apb_write = write_q;
    assign apb_addr  = addr_q;
    assign apb_wdata = wdata_q;

endmodule

// File: tb/tb_gpll_reconfig_ctrl.sv
// Randomized bench for gpll_reconfig_ctrl: APB slave/register model, PLL lock model and
// a transaction-level expectation of each reconfiguration request.
module tb_gpll_reconfig_ctrl;

    localparam int NP  = 3;
    localparam int NW  = 8;
    localparam int RH  = 16;
    localparam int LS  = 8;
    localparam int LT  = 100;
    localparam int PWB = 2;
    localparam int BUDGET = 2000;

    localparam logic [4:0] EXP_ADDR [8] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h08, 5'h09, 5'h0c};
    localparam logic [15:0] EXP_DATA [3][8] = '{
        '{16'h0005, 16'h0028, 16'h0001, 16'h0005, 16'h0001, 16'h3c10, 16'h0a21, 16'h8001},
        '{16'h0005, 16'h0050, 16'h0001, 16'h0005, 16'h0002, 16'h3c12, 16'h0a31, 16'h8001},
        '{16'h0008, 16'h0064, 16'h0003, 16'h000a, 16'h0004, 16'h2c08, 16'h0921, 16'h8000}
    };

    logic clk = 1'b0;
    logic rst_n, req, pll_lock, apb_ready;
    logic [PWB-1:0] prof_sel;
    logic [15:0] apb_rdata;
    logic busy, done, err, locked, pll_rst, apb_sel, apb_en, apb_write;
    logic [1:0] err_code;
    logic [4:0] apb_addr;
    logic [15:0] apb_wdata;

    int checks = 0;
    int failures = 0;

    logic [15:0] mem [32];
    logic [20:0] wr_log [$];
    logic [4:0]  rd_log [$];
    int rd_num = 0, corrupt_rd = -1, min_wait = 0, max_wait = 0, lock_mode = 0, lock_delay = 20;
    bit tie_ready = 1'b0;

    always #5 clk = ~clk;

    gpll_reconfig_ctrl #(
        .NUM_PROFILES(NP), .NUM_WRITES(NW), .RST_HOLD(RH), .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT)
    ) dut (
        .apb_clk(clk), .apb_rst_n(rst_n), .req(req), .prof_sel(prof_sel),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .locked(locked),
        .pll_lock(pll_lock), .pll_rst(pll_rst), .apb_sel(apb_sel), .apb_en(apb_en),
        .apb_write(apb_write), .apb_addr(apb_addr), .apb_wdata(apb_wdata),
        .apb_rdata(apb_rdata), .apb_ready(apb_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // APB slave: register file with random wait states and optional corrupted readback
    initial begin : apb_slave
        int wait_left;
        bit in_wait;
        logic [21:0] snap;
        wait_left = 0;
        in_wait = 1'b0;
        snap = '0;
        forever begin
            @(posedge clk); #1;
            apb_ready = tie_ready;
            if (apb_sel && !apb_en) begin
                wait_left = int'($urandom_range(min_wait, max_wait));
                in_wait = 1'b0;
            end else if (apb_sel && apb_en) begin
                if (in_wait) chk("apb_hold", 32'({apb_write, apb_addr, apb_wdata}), 32'(snap));
                if (wait_left > 0) begin
                    wait_left--;
                    in_wait = 1'b1;
                    snap = {apb_write, apb_addr, apb_wdata};
                    apb_ready = 1'b0;
                end else begin
                    in_wait = 1'b0;
                    apb_ready = 1'b1;
                    if (apb_write) begin
                        mem[apb_addr] = apb_wdata;
                        wr_log.push_back({apb_addr, apb_wdata});
                    end else begin
                        apb_rdata = (rd_num == corrupt_rd) ? ~mem[apb_addr] : mem[apb_addr];
                        rd_log.push_back(apb_addr);
                        rd_num++;
                    end
                end
            end else begin
                in_wait = 1'b0;
            end
        end
    end

    // PLL lock model: 0 normal (rises lock_delay samples after reset release), 1 never, 2 toggling
    initial begin : pll_model
        int since;
        int tcnt;
        since = 0;
        tcnt = 0;
        forever begin
            @(posedge clk); #1;
            case (lock_mode)
                0: begin
                    if (pll_rst) since = 0;
                    else if (since < 1000000) since++;
                    pll_lock = (since >= lock_delay);
                end
                1: pll_lock = 1'b0;
                default: begin
                    tcnt++;
                    if (tcnt % 5 == 0) pll_lock = ~pll_lock;
                end
            endcase
        end
    end

    task automatic run_op(input int p, input int corrupt, input int mode, input int delay,
                          input int lo_w, input int hi_w, input bit extra_req);
        int t_fall, t_end, rst_cnt, sel_rise, sel_fall, n_done, n_err, both, busy_bad, locked_bad;
        int n_exp, lat;
        bit valid, ended, prev_sel, prev_rst, exp_done;
        logic [1:0] exp_code;
        wr_log.delete();
        rd_log.delete();
        rd_num = 0;
        corrupt_rd = corrupt;
        lock_mode = mode;
        lock_delay = delay;
        min_wait = lo_w;
        max_wait = hi_w;
        valid = (p < NP);
        t_fall = -1; t_end = -1; rst_cnt = 0; sel_rise = 0; sel_fall = 0;
        n_done = 0; n_err = 0; both = 0; busy_bad = 0; locked_bad = 0; ended = 1'b0;
        @(posedge clk); #1;
        req = 1'b1;
        prof_sel = PWB'(p);
        prev_sel = apb_sel;
        prev_rst = pll_rst;
        for (int t = 1; t <= BUDGET; t++) begin
            @(posedge clk); #1;
            req = 1'b0;
            if (extra_req && t == 30) begin
                req = 1'b1;
                prof_sel = PWB'((p + 1) % NP);
            end
            if (pll_rst && sel_rise == 0 && !apb_sel) rst_cnt++;
            if (apb_sel && !prev_sel) sel_rise++;
            if (!apb_sel && prev_sel) sel_fall++;
            if (prev_rst && !pll_rst) t_fall = t;
            if (done && err) both++;
            if (done) n_done++;
            if (err) n_err++;
            if (busy !== (valid && !ended && !(done || err))) busy_bad++;
            if (busy && locked) locked_bad++;
            if ((done || err) && !ended) begin
                ended = 1'b1;
                t_end = t;
            end
            prev_sel = apb_sel;
            prev_rst = pll_rst;
            if (ended && t >= t_end + 5) break;
        end

        if (!valid) begin
            exp_code = 2'd1; n_exp = 0; exp_done = 1'b0;
        end else if (corrupt >= 0 && corrupt < NW) begin
            exp_code = 2'd2; n_exp = corrupt + 1; exp_done = 1'b0;
        end else if (mode == 1) begin
            exp_code = 2'd3; n_exp = NW; exp_done = 1'b0;
        end else begin
            exp_code = 2'd0; n_exp = NW; exp_done = 1'b1;
        end

        chk("op_ended", 32'(ended), 32'(1));
        chk("n_done", 32'(n_done), exp_done ? 32'(1) : 32'(0));
        chk("n_err", 32'(n_err), exp_done ? 32'(0) : 32'(1));
        chk("done_err_same", 32'(both), 32'(0));
        chk("err_code", 32'(err_code), 32'(exp_code));
        chk("busy_window", 32'(busy_bad), 32'(0));
        chk("wr_count", 32'(wr_log.size()), 32'(n_exp));
        chk("rd_count", 32'(rd_log.size()), 32'(n_exp));
        for (int i = 0; i < n_exp && i < wr_log.size(); i++)
            chk("wr_entry", 32'(wr_log[i]), 32'({EXP_ADDR[i], EXP_DATA[p][i]}));
        for (int i = 0; i < n_exp && i < rd_log.size(); i++)
            chk("rd_addr", 32'(rd_log[i]), 32'(EXP_ADDR[i]));
        if (!valid) begin
            chk("bad_prof_latency", 32'(t_end), 32'(1));
            chk("bad_prof_no_apb", 32'(sel_rise), 32'(0));
        end else begin
            chk("rst_hold", 32'(rst_cnt), 32'(RH));
            chk("sel_rise", 32'(sel_rise), 32'(1));
            chk("sel_fall", 32'(sel_fall), 32'(1));
            chk("locked_while_busy", 32'(locked_bad), 32'(0));
        end
        if (exp_code == 2'd2) chk("pll_rst_after_mismatch", 32'(pll_rst), 32'(1));
        if (exp_code == 2'd3) chk("timeout_latency", 32'(t_end - t_fall), 32'(LT));
        if (exp_done) begin
            lat = t_end - t_fall;
            chk("lock_latency_window", 32'((t_fall > 0) && (lat >= delay + LS - 1) && (lat <= delay + LS + 3)), 32'(1));
            chk("locked_after_done", 32'(locked), 32'(1));
            chk("pll_rst_after_done", 32'(pll_rst), 32'(0));
        end
    endtask

    initial begin : main
        bit found;
        int lk;
        int p, r, c, m;
        rst_n = 1'b0; req = 1'b0; prof_sel = '0; pll_lock = 1'b0;
        apb_ready = 1'b0; apb_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({busy, done, err, locked, pll_rst, apb_sel, apb_en, apb_write,
                                  apb_addr, apb_wdata, err_code}), 32'(0));
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        tie_ready = 1'b1;
        run_op(1, -1, 0, 51, 0, 0, 1'b0);
        tie_ready = 1'b0;
        run_op(0, -1, 0, 30, 3, 3, 1'b0);
        run_op(1, 3, 0, 30, 0, 1, 1'b0);
        run_op(0, -1, 1, 0, 0, 1, 1'b0);
        run_op(3, -1, 0, 20, 0, 0, 1'b0);
        run_op(1, -1, 0, 25, 0, 2, 1'b1);

        // Asynchronous reset while a write access is stretched
        lock_mode = 0; lock_delay = 20; min_wait = 3; max_wait = 3; corrupt_rd = -1;
        @(posedge clk); #1;
        req = 1'b1; prof_sel = PWB'(2);
        @(posedge clk); #1;
        req = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(posedge clk); #1;
            if (apb_sel && apb_en && apb_write) found = 1'b1;
        end
        chk("reach_wr_access", 32'(found), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_op_reset_outputs", 32'({busy, done, err, locked, pll_rst, apb_sel, apb_en, apb_write,
                                         apb_addr, apb_wdata, err_code}), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op(2, -1, 0, 15, 0, 2, 1'b0);

        // Lock toggling faster than the debounce window must never report locked
        lock_mode = 2;
        lk = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (k >= 10 && locked) lk++;
        end
        chk("locked_toggle", 32'(lk), 32'(0));
        lock_mode = 0;
        repeat (20) @(posedge clk);

        for (int n = 0; n < 12; n++) begin
            p = int'($urandom_range(0, 3));
            r = int'($urandom_range(0, 9));
            c = (r < 2) ? int'($urandom_range(0, NW - 1)) : -1;
            m = (r == 2) ? 1 : 0;
            run_op(p, c, m, int'($urandom_range(5, 60)), 0, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
